// File: rtl/axis_vector_arbiter.sv
// Round-robin arbiter that captures one requester's vector into a shadow register
// and serialises it as a single AXI-Stream packet tagged with the source index on axis_tid.
module axis_vector_arbiter #(
  parameter int N_REQ      = 4,
  parameter int VEC_BYTES  = 4,
  parameter int AXIS_BYTES = 1,
  parameter int MSB_FIRST  = 0,
  localparam int W     = AXIS_BYTES * 8,
  localparam int VB    = VEC_BYTES * 8,
  localparam int BEATS = VEC_BYTES / AXIS_BYTES,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CTR_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*VB-1:0] req_vec,
  input  logic                axis_tready,
  output logic                axis_tvalid,
  output logic                axis_tlast,
  output logic [W-1:0]        axis_tdata,
  output logic [ID_W-1:0]     axis_tid,
  output logic                busy
);

  // state | meaning
  // IDLE  | no packet in flight, grant window open
  // SEND  | shadow vector being serialised, one beat per tready
  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nx;
  logic [CTR_W-1:0]  ctr;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   tid;
  logic [VB-1:0]     shadow;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic              last_beat;
  logic              last_xfer;
  logic              capture;
  int                beat_sel;

  always_comb begin : arbitrate
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = (int'(ptr) + j) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  assign last_beat = (ctr == CTR_W'(BEATS - 1));
  assign last_xfer = (state == SEND) && axis_tready && last_beat;
  // reset gates the grant so req_ready reads 0 while aresetn is held low
  assign capture   = aresetn && ((state == IDLE) || last_xfer) && win_found;

  always_comb begin
    req_ready = '0;
    if (capture) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    if (capture)        state_nx = SEND;
    else if (last_xfer) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      ctr    <= '0;
      ptr    <= '0;
      tid    <= '0;
      shadow <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        shadow <= req_vec[int'(win_idx)*VB +: VB];
        tid    <= win_idx;
        ptr    <= ID_W'((int'(win_idx) + 1) % N_REQ);
        ctr    <= '0;
      end else if (state == SEND && axis_tready) begin
        ctr <= last_beat ? '0 : ctr + 1'b1;
      end
    end
  end

  always_comb begin
    beat_sel = (MSB_FIRST != 0) ? (BEATS - 1 - int'(ctr)) : int'(ctr);
  end

  assign axis_tvalid = (state == SEND);
  assign axis_tlast  = (state == SEND) && last_beat;
  assign axis_tdata  = (state == SEND) ? shadow[beat_sel*W +: W] : '0;
  assign axis_tid    = tid;
  assign busy        = (state == SEND);

endmodule

// File: tb/tb_axis_vector_arbiter.sv
// Bench for axis_vector_arbiter: three instances (LSB-first bytes, MSB-first bytes, one 32-bit
// beat) compared cycle by cycle against a queue-based packet model.
module tb_axis_vector_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aresetn;
  logic [3:0]   req_valid_a = '0, req_valid_b = '0;
  logic [127:0] req_vec_a = '0, req_vec_b = '0;
  logic         tready_a = 1'b0, tready_b = 1'b0;

  logic [3:0]  rdy0, rdy1, rdy2;
  logic        v0, v1, v2, l0, l1, l2, b0, b1, b2;
  logic [7:0]  d0, d1;
  logic [31:0] d2;
  logic [1:0]  t0, t1, t2;

  axis_vector_arbiter #(.N_REQ(4), .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid_a), .req_ready(rdy0), .req_vec(req_vec_a),
    .axis_tready(tready_a), .axis_tvalid(v0), .axis_tlast(l0), .axis_tdata(d0), .axis_tid(t0), .busy(b0));
  axis_vector_arbiter #(.N_REQ(4), .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1)) dut1 (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid_a), .req_ready(rdy1), .req_vec(req_vec_a),
    .axis_tready(tready_a), .axis_tvalid(v1), .axis_tlast(l1), .axis_tdata(d1), .axis_tid(t1), .busy(b1));
  axis_vector_arbiter #(.N_REQ(4), .VEC_BYTES(4), .AXIS_BYTES(4), .MSB_FIRST(0)) dut2 (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid_b), .req_ready(rdy2), .req_vec(req_vec_b),
    .axis_tready(tready_b), .axis_tvalid(v2), .axis_tlast(l2), .axis_tdata(d2), .axis_tid(t2), .busy(b2));

  // beat fields only matter while tvalid is high
  logic [16:0] obs0, obs1;
  logic [40:0] obs2;
  assign obs0 = {v0, b0, v0 ? {l0, d0, t0} : 11'b0, rdy0};
  assign obs1 = {v1, b1, v1 ? {l1, d1, t1} : 11'b0, rdy1};
  assign obs2 = {v2, b2, v2 ? {l2, d2, t2} : 35'b0, rdy2};

  int cmp_cnt = 0;
  int err_cnt = 0;

  bit drv_en = 0, cont = 0, drv_ready = 0;
  int p_raise = 0, p_drop = 0, p_ready = 100;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  tid;
  } beat_t;

  beat_t      qa[$], qm[$], qb[$];
  int         ptr_a = 0, ptr_b = 0;
  logic [3:0] grant_a = '0, grant_b = '0;

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int j = 0; j < 4; j++)
      if (v[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  function automatic logic [16:0] exp_a(input bit msb);
    beat_t b;
    logic [3:0] r;
    int w, n;
    n = qa.size();
    r = '0;
    if (aresetn && (n == 0 || (n == 1 && tready_a))) begin
      w = rr_pick(req_valid_a, ptr_a);
      if (w >= 0) r[w] = 1'b1;
    end
    if (n == 0) return {2'b00, 11'b0, r};
    b = msb ? qm[0] : qa[0];
    return {2'b11, b.last, b.data[7:0], b.tid, r};
  endfunction

  function automatic logic [40:0] exp_b();
    logic [3:0] r;
    int w, n;
    n = qb.size();
    r = '0;
    if (aresetn && (n == 0 || (n == 1 && tready_b))) begin
      w = rr_pick(req_valid_b, ptr_b);
      if (w >= 0) r[w] = 1'b1;
    end
    if (n == 0) return {2'b00, 35'b0, r};
    return {2'b11, qb[0].last, qb[0].data, qb[0].tid, r};
  endfunction

  // Packet model: a grant enqueues the whole packet; each accepted beat pops one entry.
  always @(posedge clk or negedge aresetn) begin : model
    int n, w;
    beat_t bt;
    logic [3:0] g;
    if (!aresetn) begin
      qa.delete(); qm.delete(); qb.delete();
      ptr_a   <= 0;
      ptr_b   <= 0;
      grant_a <= '0;
      grant_b <= '0;
    end else begin
      g = '0;
      n = qa.size();
      w = (n == 0 || (n == 1 && tready_a)) ? rr_pick(req_valid_a, ptr_a) : -1;
      if (n > 0 && tready_a) begin
        void'(qa.pop_front());
        void'(qm.pop_front());
      end
      if (w >= 0) begin
        g[w]  = 1'b1;
        ptr_a <= (w + 1) % 4;
        for (int k = 0; k < 4; k++) begin
          bt.last = (k == 3);
          bt.tid  = w[1:0];
          bt.data = {24'b0, req_vec_a[w*32 + k*8 +: 8]};
          qa.push_back(bt);
          bt.data = {24'b0, req_vec_a[w*32 + (3-k)*8 +: 8]};
          qm.push_back(bt);
        end
      end
      grant_a <= g;

      g = '0;
      n = qb.size();
      w = (n == 0 || (n == 1 && tready_b)) ? rr_pick(req_valid_b, ptr_b) : -1;
      if (n > 0 && tready_b) void'(qb.pop_front());
      if (w >= 0) begin
        g[w]    = 1'b1;
        ptr_b   <= (w + 1) % 4;
        bt.last = 1'b1;
        bt.tid  = w[1:0];
        bt.data = req_vec_b[w*32 +: 32];
        qb.push_back(bt);
      end
      grant_b <= g;
    end
  end

  // Random requesters: hold valid until granted, then drop (or re-arm with new data in cont mode).
  always @(posedge clk) begin
    #1;
    if (drv_en) begin
      for (int i = 0; i < 4; i++) begin
        if (grant_a[i]) begin
          if (cont) req_vec_a[i*32 +: 32] = $urandom;
          else      req_valid_a[i] = 1'b0;
        end else if (!req_valid_a[i] && ($urandom % 100) < p_raise) begin
          req_valid_a[i] = 1'b1;
          req_vec_a[i*32 +: 32] = $urandom;
        end else if (req_valid_a[i] && ($urandom % 100) < p_drop) begin
          req_valid_a[i] = 1'b0;
        end
        if (grant_b[i]) begin
          if (cont) req_vec_b[i*32 +: 32] = $urandom;
          else      req_valid_b[i] = 1'b0;
        end else if (!req_valid_b[i] && ($urandom % 100) < p_raise) begin
          req_valid_b[i] = 1'b1;
          req_vec_b[i*32 +: 32] = $urandom;
        end else if (req_valid_b[i] && ($urandom % 100) < p_drop) begin
          req_valid_b[i] = 1'b0;
        end
      end
      if (drv_ready) begin
        tready_a = ($urandom % 100) < p_ready;
        tready_b = ($urandom % 100) < p_ready;
      end
    end
  end

  task automatic apply_reset();
    drv_en = 0; cont = 0; drv_ready = 0;
    @(negedge clk);
    aresetn = 1'b0;
    req_valid_a = '0; req_valid_b = '0;
    tready_a = 1'b0; tready_b = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    aresetn = 1'b0;
    req_valid_a = 4'b0001; req_valid_b = 4'b0010;
    req_vec_a = {4{$urandom}}; req_vec_b = {4{$urandom}};
    tready_a = 1'b1; tready_b = 1'b1;
    #1;
    cmp_cnt++;
    if ({v0, b0, l0, d0, t0, rdy0} !== 17'h0) begin
      err_cnt++; $display("FAIL reset_dut0: got %h want 0", {v0, b0, l0, d0, t0, rdy0});
    end
    cmp_cnt++;
    if ({v1, b1, l1, d1, t1, rdy1} !== 17'h0) begin
      err_cnt++; $display("FAIL reset_dut1: got %h want 0", {v1, b1, l1, d1, t1, rdy1});
    end
    cmp_cnt++;
    if ({v2, b2, l2, d2, t2, rdy2} !== 41'h0) begin
      err_cnt++; $display("FAIL reset_dut2: got %h want 0", {v2, b2, l2, d2, t2, rdy2});
    end
    @(negedge clk);
    req_valid_a = '0; req_valid_b = '0;
    aresetn = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      cmp_cnt++;
      if ({v0, rdy0, v2, rdy2} !== 10'h0) begin
        err_cnt++; $display("FAIL idle_after_reset: got %h want 0", {v0, rdy0, v2, rdy2});
      end
    end
  endtask

  task automatic test_single();
    logic [8:0] got_l[$], got_m[$];
    logic [8:0] want_l[4], want_m[4];
    int rdy_cycles;
    want_l = '{9'h011, 9'h022, 9'h033, 9'h144};
    want_m = '{9'h044, 9'h033, 9'h022, 9'h111};
    rdy_cycles = 0;
    apply_reset();
    @(negedge clk);
    req_vec_a[63:32] = 32'h44332211;
    req_valid_a = 4'b0010;
    tready_a = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      cmp_cnt++;
      if (obs0 !== exp_a(0)) begin
        err_cnt++; $display("FAIL single_lsb c=%0d: got %h want %h", c, obs0, exp_a(0));
      end
      cmp_cnt++;
      if (obs1 !== exp_a(1)) begin
        err_cnt++; $display("FAIL single_msb c=%0d: got %h want %h", c, obs1, exp_a(1));
      end
      if (rdy0 != 4'b0) rdy_cycles++;
      if (v0 && tready_a) begin
        got_l.push_back({l0, d0});
        got_m.push_back({l1, d1});
      end
      @(negedge clk);
      req_valid_a &= ~grant_a;
    end
    cmp_cnt++;
    if (rdy_cycles != 1) begin
      err_cnt++; $display("FAIL single_ready_pulses: got %0d want 1", rdy_cycles);
    end
    cmp_cnt++;
    if (got_l.size() != 4 || got_m.size() != 4) begin
      err_cnt++; $display("FAIL single_beat_count: got %0d/%0d want 4", got_l.size(), got_m.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        cmp_cnt++;
        if (got_l[k] !== want_l[k] || got_m[k] !== want_m[k]) begin
          err_cnt++;
          $display("FAIL single_beat%0d: got %h/%h want %h/%h", k, got_l[k], got_m[k], want_l[k], want_m[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int tids[$];
    int want_tid[5];
    bit first, started;
    int idle;
    want_tid = '{0, 1, 2, 3, 0};
    first = 1; started = 0; idle = 0;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) req_vec_a[i*32 +: 32] = $urandom;
    req_valid_a = 4'hF;
    tready_a = 1'b1;
    p_raise = 0; p_drop = 0; p_ready = 100;
    cont = 1; drv_ready = 1; drv_en = 1;
    for (int c = 0; c < 24; c++) begin
      #1;
      cmp_cnt++;
      if (obs0 !== exp_a(0)) begin
        err_cnt++; $display("FAIL rr_lsb c=%0d: got %h want %h", c, obs0, exp_a(0));
      end
      cmp_cnt++;
      if (obs1 !== exp_a(1)) begin
        err_cnt++; $display("FAIL rr_msb c=%0d: got %h want %h", c, obs1, exp_a(1));
      end
      if (rdy0 != 4'b0 && v0) begin
        cmp_cnt++;
        if (!(l0 && tready_a)) begin
          err_cnt++; $display("FAIL rr_grant_on_last c=%0d: got tlast=%b want 1", c, l0);
        end
      end
      if (v0) started = 1;
      else if (started) idle++;
      if (v0 && tready_a) begin
        if (first) tids.push_back(int'(t0));
        first = l0;
      end
      @(negedge clk);
    end
    drv_en = 0; cont = 0; drv_ready = 0;
    cmp_cnt++;
    if (idle != 0) begin
      err_cnt++; $display("FAIL rr_no_bubble: got %0d idle cycles want 0", idle);
    end
    cmp_cnt++;
    if (tids.size() < 5) begin
      err_cnt++; $display("FAIL rr_packet_count: got %0d want >=5", tids.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        cmp_cnt++;
        if (tids[k] != want_tid[k]) begin
          err_cnt++; $display("FAIL rr_tid%0d: got %0d want %0d", k, tids[k], want_tid[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit prev_hold;
    logic [10:0] prev_f;
    int nbeats;
    prev_hold = 0; prev_f = '0; nbeats = 0;
    apply_reset();
    p_raise = 30; p_drop = 5; p_ready = 60;
    drv_ready = 0; drv_en = 1;
    for (int c = 0; c < 400; c++) begin
      if (c < 150) begin
        tready_a = (c % 3 == 0);
        tready_b = (c % 3 == 0);
      end else begin
        drv_ready = 1;
      end
      #1;
      cmp_cnt++;
      if (obs0 !== exp_a(0)) begin
        err_cnt++; $display("FAIL bp_lsb c=%0d: got %h want %h", c, obs0, exp_a(0));
      end
      cmp_cnt++;
      if (obs1 !== exp_a(1)) begin
        err_cnt++; $display("FAIL bp_msb c=%0d: got %h want %h", c, obs1, exp_a(1));
      end
      cmp_cnt++;
      if (obs2 !== exp_b()) begin
        err_cnt++; $display("FAIL bp_wide c=%0d: got %h want %h", c, obs2, exp_b());
      end
      if (prev_hold) begin
        cmp_cnt++;
        if ({v0, l0, d0, t0} !== {1'b1, prev_f}) begin
          err_cnt++; $display("FAIL bp_hold c=%0d: got %h want %h", c, {v0, l0, d0, t0}, {1'b1, prev_f});
        end
      end
      if (v0 && tready_a) begin
        nbeats++;
        if (l0) begin
          cmp_cnt++;
          if (nbeats != 4) begin
            err_cnt++; $display("FAIL bp_beats_per_packet c=%0d: got %0d want 4", c, nbeats);
          end
          nbeats = 0;
        end
      end
      prev_hold = v0 && !tready_a;
      prev_f = {l0, d0, t0};
      @(negedge clk);
    end
    drv_en = 0; drv_ready = 0;
  endtask

  task automatic test_reset_mid();
    int hs;
    bit got_first;
    hs = 0; got_first = 0;
    apply_reset();
    @(negedge clk);
    req_vec_a[63:32] = 32'h44332211;
    req_valid_a = 4'b0010;
    tready_a = 1'b1;
    for (int c = 0; c < 10 && hs < 2; c++) begin
      #1;
      cmp_cnt++;
      if (obs0 !== exp_a(0)) begin
        err_cnt++; $display("FAIL rmid_pre c=%0d: got %h want %h", c, obs0, exp_a(0));
      end
      if (v0 && tready_a) hs++;
      @(negedge clk);
      req_valid_a &= ~grant_a;
    end
    cmp_cnt++;
    if (hs < 2) begin
      err_cnt++; $display("FAIL rmid_timeout: got %0d beats want 2", hs);
    end
    aresetn = 1'b0;
    #1;
    cmp_cnt++;
    if ({v0, b0, l0, d0, t0, rdy0, v1} !== 18'h0) begin
      err_cnt++; $display("FAIL rmid_outputs: got %h want 0", {v0, b0, l0, d0, t0, rdy0, v1});
    end
    req_vec_a[31:0] = 32'h87654321;
    req_vec_a[95:64] = $urandom;
    req_valid_a = 4'b0101;
    @(negedge clk);
    aresetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      cmp_cnt++;
      if (obs0 !== exp_a(0)) begin
        err_cnt++; $display("FAIL rmid_post c=%0d: got %h want %h", c, obs0, exp_a(0));
      end
      if (v0 && tready_a && !got_first) begin
        got_first = 1;
        cmp_cnt++;
        if ({t0, d0} !== {2'd0, 8'h21}) begin
          err_cnt++; $display("FAIL rmid_restart: got tid=%0d data=%h want tid=0 data=21", t0, d0);
        end
      end
      @(negedge clk);
      req_valid_a &= ~grant_a;
    end
    cmp_cnt++;
    if (!got_first) begin
      err_cnt++; $display("FAIL rmid_no_restart: got no beat want tid=0 packet");
    end
  endtask

  task automatic test_wide();
    int nbeats;
    nbeats = 0;
    apply_reset();
    p_raise = 40; p_drop = 5; p_ready = 70;
    drv_ready = 1; drv_en = 1;
    for (int c = 0; c < 200; c++) begin
      #1;
      cmp_cnt++;
      if (obs2 !== exp_b()) begin
        err_cnt++; $display("FAIL wide c=%0d: got %h want %h", c, obs2, exp_b());
      end
      if (v2 && tready_b) begin
        nbeats++;
        cmp_cnt++;
        if (l2 !== 1'b1) begin
          err_cnt++; $display("FAIL wide_tlast c=%0d: got %b want 1", c, l2);
        end
      end
      @(negedge clk);
    end
    drv_en = 0; drv_ready = 0;
    cmp_cnt++;
    if (nbeats < 10) begin
      err_cnt++; $display("FAIL wide_activity: got %0d beats want >=10", nbeats);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
